// File: rtl/fifo_pkg.sv
// Constants shared by the synchronous FIFO and its read-side drain stage.
package fifo_pkg;

  localparam int unsigned FIFO_D_WIDTH    = 48;
  localparam int unsigned FIFO_RD_LATENCY = 1;
  localparam int unsigned OUT_BUF_DEPTH   = 3;
  localparam int unsigned BUF_PTR_W       = 2;
  localparam int unsigned BUF_OCC_W       = 2;

  // Circular pointer advance over the output buffer entries.
  function automatic logic [BUF_PTR_W-1:0] buf_ptr_inc(input logic [BUF_PTR_W-1:0] ptr);
    return (ptr == BUF_PTR_W'(OUT_BUF_DEPTH - 1)) ? '0 : ptr + BUF_PTR_W'(1);
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Three-entry circular buffer holding words returned by the FIFO until the
// downstream stream accepts them; head entry is presented combinationally.
module stream_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = FIFO_D_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 push_i,
  input  logic [D_WIDTH-1:0]   push_data_i,
  input  logic                 pop_i,
  output logic [BUF_OCC_W-1:0] occ_o,
  output logic [D_WIDTH-1:0]   head_o
);

  logic [D_WIDTH-1:0]   mem_q [OUT_BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_OCC_W-1:0] occ_q, occ_d;
  logic                 do_pop;

  // Pointer and occupancy update; push and pop together leave occ unchanged.
  always_comb begin
    do_pop   = pop_i & (occ_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = buf_ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = buf_ptr_inc(rd_ptr_q);
    case ({push_i, do_pop})
      2'b10:   occ_d = occ_q + BUF_OCC_W'(1);
      2'b01:   occ_d = occ_q - BUF_OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(OUT_BUF_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the synchronous FIFO into a valid/ready stream with packet framing,
// issuing reads on buffer credit so i_ready never reaches o_fifo_rd_en.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = FIFO_D_WIDTH,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_fifo_empty,
  output logic               o_fifo_rd_en,
  input  logic [D_WIDTH-1:0] i_fifo_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_last,
  output logic               o_busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [FIFO_RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [BUF_OCC_W-1:0]       occ;
  logic [2:0]                 credit_used;
  logic                       pop;

  // Credit check uses registered occupancy only; reset masks the request.
  always_comb begin
    credit_used  = 3'(occ) + 3'(inflight_q[0]);
    o_fifo_rd_en = i_rst_n & i_enable & ~i_fifo_empty &
                   (credit_used < 3'(OUT_BUF_DEPTH));
    o_valid      = (occ != '0);
    o_last       = (beat_cnt_q == LAST_BEAT);
    o_busy       = o_valid | inflight_q[0];
    pop          = o_valid & i_ready;
    inflight_d   = o_fifo_rd_en;
    beat_cnt_d   = beat_cnt_q;
    if (pop) beat_cnt_d = o_last ? '0 : beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inflight_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Returning FIFO data is pushed unconditionally; credit guarantees room.
  stream_out_buf #(
    .D_WIDTH (D_WIDTH)
  ) u_out_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .push_i      (inflight_q[0]),
    .push_data_i (i_fifo_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (o_data)
  );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain stage placed directly downstream of the synchronous FIFO. It issues FIFO read enables, absorbs the FIFO's one-cycle registered read latency, and presents the data as a valid/ready stream with packet framing (`o_last` every `PKT_LEN` beats). A 3-entry output buffer sustains one word per cycle under continuous `i_ready` with no combinational path from `i_ready` to `o_fifo_rd_en`.

## Interface
- `D_WIDTH`, default 48: data width; matches the FIFO data width.
- `PKT_LEN`, default 16: beats per packet, minimum 1.
- `CNT_W`, default `$clog2(PKT_LEN)` (minimum 1): beat counter width.

Ports (name, direction, width, meaning):
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_enable`  in  1  permits new FIFO reads; reads already in flight still complete.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_rd_en`  out  1  FIFO read request.
- `i_fifo_data`  in  D_WIDTH  FIFO read data, valid the cycle after an accepted `o_fifo_rd_en`.
- `o_valid`  out  1  stream data valid.
- `i_ready`  in  1  downstream ready.
- `o_data`  out  D_WIDTH  stream data.
- `o_last`  out  1  final beat of a packet; qualified by `o_valid`.
- `o_busy`  out  1  buffer non-empty or read in flight.

## Operation
- State:
  - `inflight` (1 bit): a read was issued last cycle.
  - `occ` (0..3): buffered words.
  - `beat_cnt` (CNT_W bits).
- Read issue (registered state only): `o_fifo_rd_en = i_enable & ~i_fifo_empty & (occ + inflight < 3)`.
- Capture: when `inflight` = 1, `i_fifo_data` is written into the buffer tail unconditionally. The credit rule guarantees space.
- Transfer occurs when `o_valid & i_ready`. The head is popped and `beat_cnt` advances.
  - `o_valid = (occ != 0)`.
  - `o_data` = head entry.
- Simultaneous capture and pop in one cycle: `occ` is unchanged. Ordering is strictly FIFO.
- Framing:
  - `o_last = (beat_cnt == PKT_LEN-1)`.
  - `beat_cnt` wraps to 0 on the transfer that carries `o_last`.
  - With `PKT_LEN` = 1, `o_last` is always 1.
- `i_enable` deasserted mid-stream: no new reads are issued. In-flight and buffered words still drain. `beat_cnt` is held, so packets resume intact.
- `o_valid`/`o_data`/`o_last` stay stable while `o_valid & ~i_ready`.
- `o_busy = (occ != 0) | inflight`.

## Timing
- Reset values: `o_fifo_rd_en` = 0, `o_valid` = 0, `o_last` = 0 (because `beat_cnt` = 0, with `PKT_LEN` > 1), `o_busy` = 0, `o_data` = 0. Reset also sets `occ` = 0, `inflight` = 0, `beat_cnt` = 0.
- Reset asserted mid-operation: buffered and in-flight words are discarded. Data returning the cycle after reset is ignored. The FIFO shares the reset, so no data is lost relative to FIFO state.
- Latency: `o_fifo_rd_en` high in cycle N → data captured at end of N+1 → `o_valid` high in N+2.
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and `i_ready` = 1.
- Backpressure: after `i_ready` falls, at most 2 further reads complete (in flight plus one issued on stale credit). `occ` never exceeds 3.
- Credit boundary: with `occ` = 3, no reads are issued until a pop occurs. The read is issued in the cycle after the pop.
- `o_fifo_rd_en` is never asserted while `i_fifo_empty` = 1 (assertion in the bench).

## Structure
- Shared package `fifo_pkg`:
  - constant `FIFO_RD_LATENCY` = 1;
  - constant `OUT_BUF_DEPTH` = 3;
  - `D_WIDTH` default used by both the FIFO and this block.
- Sub-module `stream_out_buf`: a 3-entry circular buffer with push/pop, `occ` output and head data, roughly 80 lines. The top level holds the credit logic, `inflight` flag and beat counter.

## Test plan
- Reset then idle: FIFO empty, `i_ready` = 1 → `o_fifo_rd_en` = 0, `o_valid` = 0, `o_busy` = 0 for 20 cycles.
- Single word: FIFO holds 48'hA5A5_0000_0001 → `o_fifo_rd_en` pulses one cycle, `o_valid` rises 2 cycles later with that data; `o_last` = 0 at `PKT_LEN` = 4.
- Streaming with framing: FIFO preloaded with 0..11, `PKT_LEN` = 4, `i_ready` = 1 → 12 consecutive beats, one per cycle, with `o_last` high on data 3, 7 and 11.
- Backpressure: stream 0..7 with `i_ready` low for 10 cycles mid-stream → `occ` peaks at 3, no read is issued at `occ` = 3, output data stays stable, and the full sequence 0..7 arrives in order without loss.
- `i_enable` toggle: deassert after 5 reads are issued → exactly 5 words are delivered, then `o_busy` falls. Re-enable → the stream continues at beat index 5 mod `PKT_LEN`.
- Mid-stream reset: assert `i_rst_n` = 0 for 1 cycle with `occ` = 2 and `inflight` = 1 → next cycle `o_valid` = 0, `occ` = 0, `beat_cnt` = 0, and the returning data is dropped.
